// File: rtl/ms_universal_register.sv
// WIDTH-bit master-slave register with load, set/reset, toggle, shift and count modes.
// Latency: mid_Q is the combinational next state; Q, carry_out and sr_conflict update one clk edge later.
// Backpressure: none; en=0 holds state, and rst (synchronous, active-high) overrides en and mode.
module ms_universal_register #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int              SR_PRIO   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             ser_in,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic [WIDTH-1:0] mid_Q,
    output logic             ser_out,
    output logic             carry_out,
    output logic             sr_conflict
);

    localparam logic [2:0] MODE_HOLD   = 3'd0;
    localparam logic [2:0] MODE_LOAD   = 3'd1;
    localparam logic [2:0] MODE_SETRST = 3'd2;
    localparam logic [2:0] MODE_TOGGLE = 3'd3;
    localparam logic [2:0] MODE_SHL    = 3'd4;
    localparam logic [2:0] MODE_SHR    = 3'd5;
    localparam logic [2:0] MODE_CNT_UP = 3'd6;
    localparam logic [2:0] MODE_CNT_DN = 3'd7;

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] q_q, q_d;
    logic             carry_q, carry_d;
    logic             conflict_q, conflict_d;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] mode_next;

    // Per-bit set/reset resolution; a simultaneous S and R is settled by SR_PRIO.
    always_comb begin
        sr_next = q_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (S[i] && !R[i]) begin
                sr_next[i] = 1'b1;
            end else if (R[i] && !S[i]) begin
                sr_next[i] = 1'b0;
            end else if (S[i] && R[i]) begin
                if (SR_PRIO == 1) begin
                    sr_next[i] = 1'b1;
                end else if (SR_PRIO == 2) begin
                    sr_next[i] = 1'b0;
                end else begin
                    sr_next[i] = q_q[i];
                end
            end
        end
    end

    // Master-stage value: next state selected by mode, held when en is low.
    always_comb begin
        mode_next = q_q;
        if (en) begin
            case (mode)
                MODE_HOLD:   mode_next = q_q;
                MODE_LOAD:   mode_next = D;
                MODE_SETRST: mode_next = sr_next;
                MODE_TOGGLE: mode_next = q_q ^ D;
                MODE_SHL:    mode_next = {q_q[WIDTH-2:0], ser_in};
                MODE_SHR:    mode_next = {ser_in, q_q[WIDTH-1:1]};
                MODE_CNT_UP: mode_next = q_q + ONE;
                MODE_CNT_DN: mode_next = q_q - ONE;
                default:     mode_next = q_q;
            endcase
        end
    end

    // Next-state for slave, wrap flag and sticky conflict flag; reset value shows on mid_Q while rst is high.
    always_comb begin
        q_d        = rst ? RESET_VAL : mode_next;
        carry_d    = en && (((mode == MODE_CNT_UP) && (q_q == ALL_ONES)) ||
                            ((mode == MODE_CNT_DN) && (q_q == '0)));
        conflict_d = conflict_q || (en && (mode == MODE_SETRST) && (|(S & R)));
    end

    // Slave stage: capture master value on the rising edge, synchronous reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q        <= RESET_VAL;
            carry_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            carry_q    <= carry_d;
            conflict_q <= conflict_d;
        end
    end

    // Serial output is the bit leaving the register this cycle, only while a shift is enabled.
    always_comb begin
        ser_out = 1'b0;
        if (en && (mode == MODE_SHL)) begin
            ser_out = q_q[WIDTH-1];
        end else if (en && (mode == MODE_SHR)) begin
            ser_out = q_q[0];
        end
    end

    assign Q           = q_q;
    assign Qbar        = ~q_q;
    assign mid_Q       = q_d;
    assign carry_out   = carry_q;
    assign sr_conflict = conflict_q;

endmodule

// File: tb/tb_ms_universal_register.sv
module tb_ms_universal_register;

    localparam int SEL_Q    = 0;
    localparam int SEL_QBAR = 1;
    localparam int SEL_MID  = 2;
    localparam int SEL_SER  = 3;
    localparam int SEL_CRY  = 4;
    localparam int SEL_CONF = 5;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, en, ser_in;
    logic [2:0] mode;
    logic [7:0] D, S, R;
    logic [7:0] Q, Qbar, mid_Q;
    logic       ser_out, carry_out, sr_conflict;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    ms_universal_register #(
        .WIDTH    (8),
        .RESET_VAL(8'hA5),
        .SR_PRIO  (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .D          (D),
        .S          (S),
        .R          (R),
        .ser_in     (ser_in),
        .Q          (Q),
        .Qbar       (Qbar),
        .mid_Q      (mid_Q),
        .ser_out    (ser_out),
        .carry_out  (carry_out),
        .sr_conflict(sr_conflict)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs just after the rising edge.
    task automatic cyc(input logic r_rst, input logic r_en, input logic [2:0] r_mode,
                       input logic [7:0] r_d, input logic [7:0] r_s, input logic [7:0] r_r,
                       input logic r_ser);
        @(posedge clk);
        #1;
        rst = r_rst; en = r_en; mode = r_mode;
        D = r_d; S = r_s; R = r_r; ser_in = r_ser;
    endtask

    task automatic expect_val(input string name, input int sel, input logic [7:0] val);
        exp_t e;
        e.name = name; e.sel = sel; e.val = val;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are stable mid-cycle; pop and compare everything expected for this cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                exp_t e;
                logic [7:0] act;
                e = exp_q.pop_front();
                case (e.sel)
                    SEL_Q:    act = Q;
                    SEL_QBAR: act = Qbar;
                    SEL_MID:  act = mid_Q;
                    SEL_SER:  act = {7'd0, ser_out};
                    SEL_CRY:  act = {7'd0, carry_out};
                    default:  act = {7'd0, sr_conflict};
                endcase
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.val);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; mode = 3'd0; D = '0; S = '0; R = '0; ser_in = 1'b0;

        // Reset cycle: master already shows the reset value.
        cyc(1, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0);
        expect_val("rst_mid", SEL_MID, 8'hA5);

        cyc(0, 1, 3'd1, 8'h3C, 8'h00, 8'h00, 0);
        expect_val("rst_q", SEL_Q, 8'hA5);
        expect_val("rst_qbar", SEL_QBAR, 8'h5A);
        expect_val("rst_carry", SEL_CRY, 8'h00);
        expect_val("rst_conf", SEL_CONF, 8'h00);
        expect_val("load_mid", SEL_MID, 8'h3C);

        cyc(0, 1, 3'd3, 8'h0F, 8'h00, 8'h00, 0);
        expect_val("load_q", SEL_Q, 8'h3C);
        expect_val("toggle_mid", SEL_MID, 8'h33);

        cyc(0, 1, 3'd1, 8'h00, 8'h00, 8'h00, 0);
        expect_val("toggle_q", SEL_Q, 8'h33);
        expect_val("toggle_qbar", SEL_QBAR, 8'hCC);

        cyc(0, 1, 3'd2, 8'h00, 8'h81, 8'h01, 0);
        expect_val("pre_sr_q", SEL_Q, 8'h00);
        expect_val("sr_mid", SEL_MID, 8'h80);
        expect_val("sr_conf_pre", SEL_CONF, 8'h00);

        cyc(0, 1, 3'd1, 8'hFF, 8'h00, 8'h00, 0);
        expect_val("sr_q", SEL_Q, 8'h80);
        expect_val("sr_conf_set", SEL_CONF, 8'h01);

        cyc(0, 1, 3'd6, 8'h00, 8'h00, 8'h00, 0);
        expect_val("up_start_q", SEL_Q, 8'hFF);
        expect_val("up_mid", SEL_MID, 8'h00);
        expect_val("load_no_carry", SEL_CRY, 8'h00);
        expect_val("conf_sticky1", SEL_CONF, 8'h01);

        cyc(0, 1, 3'd7, 8'h00, 8'h00, 8'h00, 0);
        expect_val("up_wrap_q", SEL_Q, 8'h00);
        expect_val("up_carry", SEL_CRY, 8'h01);
        expect_val("dn_mid", SEL_MID, 8'hFF);

        cyc(0, 1, 3'd0, 8'h00, 8'h00, 8'h00, 0);
        expect_val("dn_wrap_q", SEL_Q, 8'hFF);
        expect_val("dn_carry", SEL_CRY, 8'h01);
        expect_val("hold_mid", SEL_MID, 8'hFF);

        cyc(0, 1, 3'd1, 8'h80, 8'h00, 8'h00, 0);
        expect_val("hold_q", SEL_Q, 8'hFF);
        expect_val("carry_drop", SEL_CRY, 8'h00);
        expect_val("conf_sticky2", SEL_CONF, 8'h01);

        cyc(0, 1, 3'd4, 8'h00, 8'h00, 8'h00, 1);
        expect_val("shl_start_q", SEL_Q, 8'h80);
        expect_val("shl_ser_out", SEL_SER, 8'h01);
        expect_val("shl_mid", SEL_MID, 8'h01);

        cyc(0, 1, 3'd5, 8'h00, 8'h00, 8'h00, 0);
        expect_val("shl_q", SEL_Q, 8'h01);
        expect_val("shr_ser_out", SEL_SER, 8'h01);
        expect_val("shr_mid", SEL_MID, 8'h00);

        cyc(0, 1, 3'd1, 8'h05, 8'h00, 8'h00, 0);
        expect_val("shr_q", SEL_Q, 8'h00);
        expect_val("load_ser_out", SEL_SER, 8'h00);
        expect_val("shl_no_carry", SEL_CRY, 8'h00);

        // en low with a count mode selected: nothing moves.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 3'd6, 8'h00, 8'h00, 8'h00, 1);
            expect_val("en0_q", SEL_Q, 8'h05);
            expect_val("en0_mid", SEL_MID, 8'h05);
        end
        cyc(0, 0, 3'd4, 8'h00, 8'h00, 8'h00, 1);
        expect_val("en0_q", SEL_Q, 8'h05);
        expect_val("en0_ser_out", SEL_SER, 8'h00);

        cyc(0, 1, 3'd6, 8'h00, 8'h00, 8'h00, 0);
        expect_val("cnt_q0", SEL_Q, 8'h05);
        expect_val("cnt_mid0", SEL_MID, 8'h06);

        cyc(0, 1, 3'd6, 8'h00, 8'h00, 8'h00, 0);
        expect_val("cnt_q1", SEL_Q, 8'h06);
        expect_val("cnt_mid1", SEL_MID, 8'h07);

        // Synchronous reset mid-count: outputs keep old values until the edge.
        cyc(1, 1, 3'd6, 8'h00, 8'h00, 8'h00, 0);
        expect_val("rst_pre_q", SEL_Q, 8'h07);
        expect_val("rst_pre_mid", SEL_MID, 8'hA5);
        expect_val("rst_pre_conf", SEL_CONF, 8'h01);

        cyc(0, 0, 3'd6, 8'h00, 8'h00, 8'h00, 0);
        expect_val("rst2_q", SEL_Q, 8'hA5);
        expect_val("rst2_qbar", SEL_QBAR, 8'h5A);
        expect_val("rst2_conf", SEL_CONF, 8'h00);
        expect_val("rst2_carry", SEL_CRY, 8'h00);

        @(posedge clk);
        @(posedge clk);
        stim_done = 1'b1;
    end

    // End of run: every queued expectation must have been consumed.
    initial begin
        fork
            wait (stim_done);
            #20000;
        join_any
        disable fork;
        checks++;
        if (!stim_done || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: done=%0d pending=%0d expected done=1 pending=0",
                     stim_done, exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
